// File: rtl/seq_mul_param.sv
// Parametrised shift-add sequential multiplier with valid/ready intake and done pulse.
// Define SEQ_MUL_SIGNED_EN to add the signed_mode port and two's-complement products.
module seq_mul_param #(
    parameter int unsigned WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
`ifdef SEQ_MUL_SIGNED_EN
    input  logic                 signed_mode,
`endif
    output logic                 busy,
    output logic [2*WIDTH-1:0]   result,
    output logic                 out_done
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam int unsigned PW = 2 * WIDTH;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [PW-1:0]   result_q, result_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   ext_a;
    logic [PW-1:0]   addend;
    logic            last;
`ifdef SEQ_MUL_SIGNED_EN
    logic            sgn_q, sgn_d;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            result_q <= '0;
            count_q  <= '0;
`ifdef SEQ_MUL_SIGNED_EN
            sgn_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            count_q  <= count_d;
`ifdef SEQ_MUL_SIGNED_EN
            sgn_q    <= sgn_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        result_d = result_q;
        count_d  = count_q;
`ifdef SEQ_MUL_SIGNED_EN
        sgn_d    = sgn_q;
`endif
        // Multiplicand is stored pre-extended so each iteration is a plain shift.
        ext_a = {{WIDTH{1'b0}}, a};
`ifdef SEQ_MUL_SIGNED_EN
        if (signed_mode) begin
            ext_a = {{WIDTH{a[WIDTH-1]}}, a};
        end
`endif
        last   = (count_q == CW'(WIDTH - 1));
        addend = mplier_q[0] ? (mcand_q << count_q) : '0;

        unique case (state_q)
            StIdle, StDone: begin
                if (in_valid) begin
                    state_d  = StRun;
                    mcand_d  = ext_a;
                    mplier_d = b;
                    acc_d    = '0;
                    count_d  = '0;
`ifdef SEQ_MUL_SIGNED_EN
                    sgn_d    = signed_mode;
`endif
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
`ifdef SEQ_MUL_SIGNED_EN
                // MSB of a two's-complement multiplier carries negative weight.
                acc_d = (sgn_q && last) ? (acc_q - addend) : (acc_q + addend);
`else
                acc_d = acc_q + addend;
`endif
                mplier_d = mplier_q >> 1;
                count_d  = count_q + CW'(1);
                if (last) begin
                    result_d = acc_d;
                    state_d  = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign in_ready = (state_q != StRun);
    assign busy     = (state_q == StRun);
    assign out_done = (state_q == StDone);
    assign result   = result_q;

endmodule

// File: doc/seq_mul_param.md
# seq_mul_param

Parametrised sequential shift-add multiplier; successor to the fixed 4×4 sequential multiplier used in the tiny-tapeout tiles. Accepts two WIDTH-bit operands over a valid/ready handshake, computes the 2·WIDTH-bit product in WIDTH iterations, and flags completion with a one-cycle done pulse. Sits between the tile I/O wrapper and the operand pins; optional two's-complement mode.

## Interface

Parameters:
- WIDTH, 4, operand width in bits; legal 2..32.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand pair present on a/b.
- in_ready  output  1  block can accept operands this cycle.
- a  input  WIDTH  multiplicand.
- b  input  WIDTH  multiplier.
- signed_mode  input  1  1 = treat a/b as two's complement. Present only with SEQ_MUL_SIGNED_EN.
- busy  output  1  iteration in progress.
- result  output  2·WIDTH  product; holds until the next completion.
- out_done  output  1  single-cycle pulse; result valid and new.

## Operation

- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1, busy=0. On in_valid: latch a into multiplicand register, b into multiplier shift register, latch signed_mode, clear accumulator, count=0, go to RUN.
- RUN: in_ready=0, busy=1. Each cycle: if multiplier LSB=1, add multiplicand (sign- or zero-extended to 2·WIDTH, shifted by count) to accumulator; shift multiplier right; count++. After the WIDTH-th iteration, copy accumulator to result, go to DONE.
- DONE: out_done=1, busy=0, in_ready=1. If in_valid, latch new operands and go to RUN (back-to-back); else go to IDLE.
- Signed iteration: on the final (MSB) iteration with signed_mode=1, the partial product is subtracted instead of added; multiplicand is sign-extended. Result is the exact two's-complement product.
- Arithmetic is modulo 2^(2·WIDTH); the product always fits, no overflow flag.
- in_valid while in_ready=0 is ignored; a/b/signed_mode changes during RUN have no effect.
- Counter width $clog2(WIDTH+1); count never wraps.

## Timing

- Reset (async, any state including mid-RUN): state=IDLE, result=0, out_done=0, busy=0, in_ready=1, accumulator/count=0. Operation in flight is discarded; no out_done.
- Operands accepted at edge E0 (in_valid && in_ready). Iterations at edges E1..EWIDTH; result updates at EWIDTH; out_done high in the cycle following EWIDTH.
- Latency: out_done asserted WIDTH cycles after the accepting edge.
- Throughput: one product per WIDTH+1 cycles with continuous in_valid.
- out_done exactly one cycle per product; never asserted from IDLE or RUN.
- result changes only at the completing edge or on reset.

## Configuration

- SEQ_MUL_SIGNED_EN defined: signed_mode port exists; signed_mode=1 selects two's-complement product; signed_mode=0 is unsigned.
- Not defined: port absent; all operands unsigned; final iteration always adds; no subtract logic synthesized.
- Timing identical in both builds.

## Test plan

- Reset: assert reset mid-cycle with clock running -> immediately result=0, out_done=0, busy=0, in_ready=1.
- WIDTH=4 unsigned: a=15, b=15, pulse in_valid -> out_done exactly 4 cycles after accepting edge, result=0x00E1; a=0, b=9 -> result=0x0000.
- Back-to-back: hold in_valid with (3,5) then (7,6) -> out_done pulses 5 cycles apart, results 15 then 42; in_valid during RUN ignored.
- Reset mid-operation: accept (9,9), assert reset after 2 cycles -> no out_done, result=0; next (2,3) -> 6.
- SEQ_MUL_SIGNED_EN, WIDTH=4, signed_mode=1: (-8,-8) -> 0x40; (-8,7) -> 0xC8; (7,-1) -> 0xF9; signed_mode=0 (0x8,0x8) -> 0x40, (0x8,0x7) -> 0x38.
- WIDTH=8 unsigned: (255,255) -> 0xFE01, out_done 8 cycles after accept; randomized 1000 pairs vs. reference product.
